// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
//
// Sequencing controller for the UART receiver. Walks each frame through
// START, DATA, optional PARITY and STOP using an edge counter (position inside
// the current bit) and a bit counter (data bit index). It issues one-cycle
// check/shift strobes to the RX datapath sub-blocks at the check point
// K = P/2 + 2, where the sampler's majority vote has settled, and reports the
// frame outcome as one-cycle result pulses.
//
// Ports
//   CLK           receiver oversampling clock
//   RST           asynchronous, active-low reset
//   rx_in         synchronized serial line, idle high
//   par_en        frame carries a parity bit (latched at frame start)
//   prescale      oversampling ratio P: 8, 16 or 32 (latched at frame start)
//   start_glitch  start checker result, valid while strt_chk_en is high
//   par_err       parity checker result, valid while par_chk_en is high
//   stp_err       stop checker result, valid while stp_chk_en is high
//   edge_cnt      position inside the current bit, 0 .. P-1
//   dat_samp_en   data sampler enable, high in every non-IDLE state
//   strt_chk_en   start-check strobe
//   deser_en      deserializer shift strobe
//   par_chk_en    parity-check strobe
//   stp_chk_en    stop-check strobe
//   data_valid    frame accepted
//   par_error     frame rejected because of parity
//   frm_error     frame rejected because of the stop bit
// -----------------------------------------------------------------------------
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               rx_in,
  input  logic               par_en,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               start_glitch,
  input  logic               par_err,
  input  logic               stp_err,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic               dat_samp_en,
  output logic               strt_chk_en,
  output logic               deser_en,
  output logic               par_chk_en,
  output logic               stp_chk_en,
  output logic               data_valid,
  output logic               par_error,
  output logic               frm_error
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e             state_q,       state_d;
  logic [PRESC_W-1:0] edge_cnt_q,    edge_cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q,     bit_cnt_d;
  logic [PRESC_W-1:0] p_q,           p_d;
  logic               pe_q,          pe_d;
  logic               pe_flag_q,     pe_flag_d;
  logic               samp_en_q,     samp_en_d;
  logic               strt_en_q,     strt_en_d;
  logic               deser_en_q,    deser_en_d;
  logic               par_en_q,      par_en_d;
  logic               stp_en_q,      stp_en_d;
  logic               data_valid_q,  data_valid_d;
  logic               par_error_q,   par_error_d;
  logic               frm_error_q,   frm_error_d;

  logic [PRESC_W-1:0] k_cur;
  logic [PRESC_W-1:0] k_nxt;
  logic               at_k;
  logic               at_wrap;
  logic               at_k_nxt;

  always_comb begin
    // NOTE: every variable gets a default first, so no path through the case
    // leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    edge_cnt_d   = edge_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    p_d          = p_q;
    pe_d         = pe_q;
    pe_flag_d    = pe_flag_q;
    data_valid_d = 1'b0;
    par_error_d  = 1'b0;
    frm_error_d  = 1'b0;

    k_cur   = (p_q >> 1) + PRESC_W'(2);
    at_k    = (edge_cnt_q == k_cur);
    at_wrap = (edge_cnt_q == (p_q - PRESC_W'(1)));

    // Free-running bit-period counter while a frame is in flight.
    if (state_q != IDLE) begin
      edge_cnt_d = at_wrap ? '0 : edge_cnt_q + PRESC_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (!rx_in) begin
          state_d   = START;
          bit_cnt_d = '0;
          p_d       = prescale;
          pe_d      = par_en;
          pe_flag_d = 1'b0;
        end
      end
      START: begin
        if (at_k && start_glitch) begin
          state_d = IDLE;
        end else if (at_wrap) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (at_wrap) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d = pe_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        if (at_k) begin
          pe_flag_d = par_err;
        end
        if (at_wrap) begin
          state_d = STOP;
        end
      end
      STOP: begin
        // Leave at the check point so a start edge in the second half of the
        // stop bit is already seen from IDLE.
        if (at_k) begin
          state_d      = IDLE;
          data_valid_d = !pe_flag_q && !stp_err;
          par_error_d  = pe_flag_q;
          frm_error_d  = stp_err;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) begin
      edge_cnt_d = '0;
    end

    // Strobes are registered: decode them from the next-cycle state and
    // counter so the flop output lines up with edge_cnt == K.
    k_nxt      = (p_d >> 1) + PRESC_W'(2);
    at_k_nxt   = (edge_cnt_d == k_nxt);
    samp_en_d  = (state_d != IDLE);
    strt_en_d  = (state_d == START)  && at_k_nxt;
    deser_en_d = (state_d == DATA)   && at_k_nxt;
    par_en_d   = (state_d == PARITY) && at_k_nxt;
    stp_en_d   = (state_d == STOP)   && at_k_nxt;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      edge_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      p_q          <= '0;
      pe_q         <= 1'b0;
      pe_flag_q    <= 1'b0;
      samp_en_q    <= 1'b0;
      strt_en_q    <= 1'b0;
      deser_en_q   <= 1'b0;
      par_en_q     <= 1'b0;
      stp_en_q     <= 1'b0;
      data_valid_q <= 1'b0;
      par_error_q  <= 1'b0;
      frm_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      edge_cnt_q   <= edge_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      p_q          <= p_d;
      pe_q         <= pe_d;
      pe_flag_q    <= pe_flag_d;
      samp_en_q    <= samp_en_d;
      strt_en_q    <= strt_en_d;
      deser_en_q   <= deser_en_d;
      par_en_q     <= par_en_d;
      stp_en_q     <= stp_en_d;
      data_valid_q <= data_valid_d;
      par_error_q  <= par_error_d;
      frm_error_q  <= frm_error_d;
    end
  end

  assign edge_cnt    = edge_cnt_q;
  assign dat_samp_en = samp_en_q;
  assign strt_chk_en = strt_en_q;
  assign deser_en    = deser_en_q;
  assign par_chk_en  = par_en_q;
  assign stp_chk_en  = stp_en_q;
  assign data_valid  = data_valid_q;
  assign par_error   = par_error_q;
  assign frm_error   = frm_error_q;

endmodule
